// File: rtl/mmio_pkg.sv
// Shared register offsets, bit positions and decode struct for the MMIO UART controller.
package mmio_pkg;

  localparam logic [7:0] OFS_CTRL    = 8'h00;
  localparam logic [7:0] OFS_RX_DATA = 8'h04;
  localparam logic [7:0] OFS_TX_DATA = 8'h08;
  localparam logic [7:0] OFS_STATUS  = 8'h0C;
  localparam logic [7:0] OFS_CYCLE   = 8'h10;
  localparam logic [7:0] OFS_INSTR   = 8'h14;
  localparam logic [7:0] OFS_CNT_CLR = 8'h18;
  localparam logic [7:0] OFS_STK_CLR = 8'h1C;
  localparam logic [7:0] OFS_IE      = 8'h20;

  localparam int unsigned CTRL_TX_NOTFULL  = 0;
  localparam int unsigned CTRL_RX_NONEMPTY = 1;
  localparam int unsigned IE_RX            = 0;
  localparam int unsigned IE_TX            = 1;

  typedef struct packed {
    logic rx_pop;
    logic tx_push;
    logic cnt_clr;
    logic stk_clr;
  } mmio_dec_t;

endpackage

// File: rtl/mmio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; push ignored when full,
// pop ignored when empty.
module mmio_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // Full is judged on the registered state, so a same-cycle pop never makes room.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Buffered UART MMIO block with cycle/instret counters and registered load data.
// Define MMIO_IRQ_EN to add the interrupt-enable register at 0x20 and the irq output.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_sel,
  input  logic [7:0]        cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  input  logic              inst_retire,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
`ifdef MMIO_IRQ_EN
  output logic              irq,
`endif
  output logic              uart_rx_ready
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  logic              ld, st;
  mmio_dec_t         dec;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [DATA_W-1:0] rx_head;
  logic [CNT_W-1:0]  cyc_q, inst_q;
  logic              tx_ovf_q, rx_unf_q, tx_ovf_d, rx_unf_d;
  logic [31:0]       rd_val;
  logic              unused_wdata;

  assign ld = cpu_sel & cpu_re;
  assign st = cpu_sel & cpu_we;

  always_comb begin
    dec         = '0;
    dec.rx_pop  = ld && (cpu_addr == OFS_RX_DATA);
    dec.tx_push = st && (cpu_addr == OFS_TX_DATA);
    dec.cnt_clr = st && (cpu_addr == OFS_CNT_CLR);
    dec.stk_clr = st && (cpu_addr == OFS_STK_CLR);
  end

  mmio_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dec.tx_push),
    .wdata (cpu_wdata[DATA_W-1:0]),
    .pop   (uart_tx_ready),
    .rdata (uart_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  mmio_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_valid),
    .wdata (uart_rx_data),
    .pop   (dec.rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign uart_tx_valid = ~tx_empty;
  assign uart_rx_ready = ~rx_full;

  // A new event in the same cycle as the clear store leaves the flag set.
  assign tx_ovf_d = (tx_ovf_q & ~dec.stk_clr) | (dec.tx_push & tx_full);
  assign rx_unf_d = (rx_unf_q & ~dec.stk_clr) | (dec.rx_pop & rx_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q    <= '0;
      inst_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      if (dec.cnt_clr) begin
        cyc_q  <= '0;
        inst_q <= '0;
      end else begin
        cyc_q <= cyc_q + 1'b1;
        if (inst_retire) inst_q <= inst_q + 1'b1;
      end
    end
  end

`ifdef MMIO_IRQ_EN
  logic [1:0] ie_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q <= '0;
      irq  <= 1'b0;
    end else begin
      if (st && (cpu_addr == OFS_IE)) ie_q <= cpu_wdata[1:0];
      irq <= (ie_q[IE_RX] & ~rx_empty) | (ie_q[IE_TX] & tx_empty);
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (cpu_addr)
      OFS_CTRL: begin
        rd_val[CTRL_RX_NONEMPTY] = ~rx_empty;
        rd_val[CTRL_TX_NOTFULL]  = ~tx_full;
      end
      OFS_RX_DATA: if (!rx_empty) rd_val = 32'(rx_head);
      OFS_STATUS:  rd_val = {16'(tx_count), 14'(rx_count), tx_ovf_q, rx_unf_q};
      OFS_CYCLE:   rd_val = 32'(cyc_q);
      OFS_INSTR:   rd_val = 32'(inst_q);
`ifdef MMIO_IRQ_EN
      OFS_IE:      rd_val = 32'(ie_q);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     cpu_rdata <= '0;
    else if (ld) cpu_rdata <= rd_val;
  end

  assign unused_wdata = ^cpu_wdata;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl: directed tables, corner sequences and a random
// phase compared against a queue-based reference model.
module tb_mmio_uart_ctrl;

  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_sel, cpu_we, cpu_re, inst_retire;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata, rdata4;
  logic [7:0]  uart_tx_data, uart_rx_data, tx_data4;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;
  logic        tx_valid4, rx_ready4;
`ifdef MMIO_IRQ_EN
  logic        irq, irq4;
`endif

  always #5 clk = ~clk;

  mmio_uart_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_sel       (cpu_sel),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
`ifdef MMIO_IRQ_EN
    .irq           (irq),
`endif
    .uart_rx_ready (uart_rx_ready)
  );

  // Narrow-counter instance sharing all stimulus; only its load data is checked.
  mmio_uart_ctrl #(.CNT_W(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .cpu_sel       (cpu_sel),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (rdata4),
    .inst_retire   (inst_retire),
    .uart_tx_data  (tx_data4),
    .uart_tx_valid (tx_valid4),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
`ifdef MMIO_IRQ_EN
    .irq           (irq4),
`endif
    .uart_rx_ready (rx_ready4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues for the FIFOs, plain integers for counters.
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic [31:0] m_cyc, m_inst, m_rdata, m_rdata4, m_rd;
  logic [1:0]  m_ie;
  bit          m_ovf, m_unf, m_irq, m_irq_n, m_ld, m_st;
  int          m_txn, m_rxn;

  always @(posedge clk) begin
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_cyc = 0; m_inst = 0; m_rdata = 0; m_rdata4 = 0;
      m_ie = 0; m_ovf = 0; m_unf = 0; m_irq = 0;
    end else begin
      m_ld  = cpu_sel && cpu_re;
      m_st  = cpu_sel && cpu_we;
      m_txn = m_tx.size();
      m_rxn = m_rx.size();
      case (cpu_addr)
        8'h00: m_rd = {30'b0, m_rxn > 0, m_txn < TXD};
        8'h04: m_rd = (m_rxn > 0) ? {24'b0, m_rx[0]} : 32'h0;
        8'h0C: m_rd = (32'(m_txn) << 16) | (32'(m_rxn) << 2) | {30'b0, m_ovf, m_unf};
        8'h10: m_rd = m_cyc;
        8'h14: m_rd = m_inst;
`ifdef MMIO_IRQ_EN
        8'h20: m_rd = {30'b0, m_ie};
`endif
        default: m_rd = 0;
      endcase
      m_irq_n = (m_ie[0] && m_rxn > 0) || (m_ie[1] && m_txn == 0);
      if (m_ld) begin
        m_rdata  = m_rd;
        m_rdata4 = (cpu_addr == 8'h10) ? m_cyc % 16 :
                   (cpu_addr == 8'h14) ? m_inst % 16 : m_rd;
      end
      if (m_st && cpu_addr == 8'h1C) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (uart_tx_ready && m_txn > 0) void'(m_tx.pop_front());
      if (m_st && cpu_addr == 8'h08) begin
        if (m_txn < TXD) m_tx.push_back(cpu_wdata[7:0]);
        else m_ovf = 1;
      end
      if (m_ld && cpu_addr == 8'h04) begin
        if (m_rxn > 0) void'(m_rx.pop_front());
        else m_unf = 1;
      end
      if (uart_rx_valid && m_rxn < RXD) m_rx.push_back(uart_rx_data);
      if (m_st && cpu_addr == 8'h18) begin
        m_cyc  = 0;
        m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1;
        if (inst_retire) m_inst = m_inst + 1;
      end
`ifdef MMIO_IRQ_EN
      if (m_st && cpu_addr == 8'h20) m_ie = cpu_wdata[1:0];
`endif
      m_irq = m_irq_n;
    end
  end

  task automatic check_outputs();
    check("rdata", cpu_rdata, m_rdata);
    check("rdata_cnt4", rdata4, m_rdata4);
    check("tx_valid", 32'(uart_tx_valid), 32'(m_tx.size() > 0));
    if (m_tx.size() > 0) check("tx_data", 32'(uart_tx_data), 32'(m_tx[0]));
    check("rx_ready", 32'(uart_rx_ready), 32'(m_rx.size() < RXD));
`ifdef MMIO_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    cpu_sel = 0; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    inst_retire = 0; uart_rx_valid = 0; uart_rx_data = 0;
  endtask

  task automatic op(bit we, bit re, logic [7:0] addr, logic [31:0] wdata);
    cpu_sel = 1; cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
    step();
    cpu_sel = 0; cpu_we = 0; cpu_re = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    uart_tx_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("reset_rx_ready", 32'(uart_rx_ready), 32'h1);
`ifdef MMIO_IRQ_EN
    check("reset_irq", 32'(irq), 32'h0);
`endif
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          txr;
    bit          rxv;
    logic [7:0]  rxd;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(bit we, bit re, logic [7:0] addr, logic [31:0] wdata, bit txr,
                              bit rxv, logic [7:0] rxd, bit chk, logic [31:0] exp,
                              string name);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.txr = txr;
    v.rxv = rxv; v.rxd = rxd; v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic run_vec(vec_t v);
    uart_tx_ready = v.txr;
    uart_rx_valid = v.rxv;
    uart_rx_data  = v.rxd;
    cpu_sel = v.we | v.re; cpu_we = v.we; cpu_re = v.re;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    step();
    cpu_sel = 0; cpu_we = 0; cpu_re = 0; uart_rx_valid = 0;
    if (v.chk) check(v.name, cpu_rdata, v.exp);
  endtask

  vec_t va[$];
  vec_t vb[$];
  logic [7:0] addrs[11];

  initial begin
    // TX fill past capacity with the transmitter stalled.
    va.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 32'h1, "ctrl_after_reset"));
    for (int i = 0; i < 9; i++) va.push_back(mk(1, 0, 8'h08, 32'h41 + i, 0, 0, 0, 0, 0, ""));
    va.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h0008_0002, "status_tx_ovf"));
    va.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 32'h0, "ctrl_tx_full"));

    // RX traffic, underflow, sticky clear, unmapped access, RX fill, repeated TX overflow.
    vb.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h10, 0, 0, ""));
    vb.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h20, 0, 0, ""));
    vb.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h30, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 1, 32'h10, "rx_pop0"));
    vb.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 1, 32'h20, "rx_pop1"));
    vb.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 1, 32'h30, "rx_pop2"));
    vb.push_back(mk(0, 1, 8'h04, 0, 0, 0, 0, 1, 32'h0, "rx_pop_empty"));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h3, "status_ovf_unf"));
    vb.push_back(mk(1, 0, 8'h1C, 0, 0, 0, 0, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h0, "status_cleared"));
    vb.push_back(mk(1, 0, 8'h24, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h24, 0, 0, 0, 0, 1, 32'h0, "unmapped_read"));
    vb.push_back(mk(0, 1, 8'h20, 0, 0, 0, 0, 0, 0, ""));
    for (int i = 0; i < 8; i++) vb.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h80 + 8'(i), 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 32'h3, "ctrl_rx_nonempty"));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h20, "status_rx_full"));
    for (int i = 0; i < 9; i++) vb.push_back(mk(1, 0, 8'h08, 32'h60 + i, 0, 0, 0, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h0008_0022, "status_ovf_again"));
    vb.push_back(mk(1, 0, 8'h1C, 0, 0, 0, 0, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h0008_0020, "status_ovf_cleared"));
    vb.push_back(mk(1, 0, 8'h08, 32'h99, 0, 0, 0, 0, 0, ""));
    vb.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 0, 1, 32'h0008_0022, "status_ovf_reset"));

    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
    addrs[4] = 8'h10; addrs[5] = 8'h14; addrs[6] = 8'h18; addrs[7] = 8'h1C;
    addrs[8] = 8'h20; addrs[9] = 8'h24; addrs[10] = 8'h03;

    do_reset();

    // Counter wrap at CNT_W=4 measured from reset.
    repeat (17) step();
    op(0, 1, 8'h10, 0);
    check("cyc_from_reset", cpu_rdata, 32'd17);
    check("cyc_wrap_w4", rdata4, 32'd1);

    foreach (va[i]) run_vec(va[i]);

    uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(uart_tx_valid), 32'h1);
      check("drain_data", 32'(uart_tx_data), 32'h41 + i);
      step();
    end
    check("drain_done", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 0;

    foreach (vb[i]) begin
      run_vec(vb[i]);
      if (vb[i].name == "status_rx_full") check("rx_backpressure", 32'(uart_rx_ready), 32'h0);
    end

    // Counters: idle count, retire count, clear overriding a same-cycle retire.
    op(1, 0, 8'h18, 0);
    repeat (100) step();
    op(0, 1, 8'h10, 0);
    check("cyc_100", cpu_rdata, 32'd100);
    check("cyc_100_w4", rdata4, 32'd4);
    op(1, 0, 8'h18, 0);
    inst_retire = 1;
    repeat (5) step();
    inst_retire = 0;
    op(0, 1, 8'h14, 0);
    check("inst_5", cpu_rdata, 32'd5);
    inst_retire = 1;
    op(1, 0, 8'h18, 0);
    inst_retire = 0;
    op(0, 1, 8'h10, 0);
    check("cyc_cleared", cpu_rdata, 32'd0);
    op(0, 1, 8'h14, 0);
    check("inst_cleared", cpu_rdata, 32'd0);

`ifdef MMIO_IRQ_EN
    do_reset();
    op(1, 0, 8'h20, 32'h1);
    op(0, 1, 8'h20, 0);
    check("ie_readback", cpu_rdata, 32'h1);
    uart_rx_valid = 1; uart_rx_data = 8'h5A;
    step();
    uart_rx_valid = 0;
    check("irq_not_yet", 32'(irq), 32'h0);
    step();
    check("irq_rx_set", 32'(irq), 32'h1);
    op(0, 1, 8'h04, 0);
    check("irq_pop_data", cpu_rdata, 32'h5A);
    check("irq_still_set", 32'(irq), 32'h1);
    step();
    check("irq_rx_clear", 32'(irq), 32'h0);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cpu_sel       = ($urandom_range(0, 9) < 6);
      cpu_we        = $urandom_range(0, 1) == 1;
      cpu_re        = $urandom_range(0, 1) == 1;
      cpu_addr      = addrs[$urandom_range(0, 10)];
      cpu_wdata     = $urandom;
      inst_retire   = $urandom_range(0, 1) == 1;
      uart_tx_ready = $urandom_range(0, 2) == 0;
      uart_rx_valid = $urandom_range(0, 1) == 1;
      uart_rx_data  = 8'($urandom);
      if (cpu_addr == 8'h18 && $urandom_range(0, 7) != 0) cpu_we = 0;
      step();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
